bump_buzz_ctrl: RTL and testbench
=================================

BUMP_BUZZ_CTRL -- requirements
Module: bump_buzz_ctrl

Interface
REQ-001 Parameter NUM_BMP, default 2: number of active-low bump switch inputs, range 1..8.
REQ-002 Parameter DEB_CYC, default 50000: debounce qualification length in clocks.
REQ-003 Parameter BEEP_CYC, default 12500000: beep on-time and off-time in clocks.
REQ-004 Parameter TONE_W, default 15: tone counter width; buzz = counter MSB (1.526 kHz at 50 MHz).
REQ-005 Parameter FAST_SIM, default 0: when 1, effective DEB_CYC = 16 and BEEP_CYC = 64.
REQ-006 clk  in  1  50 MHz system clock; one clock domain.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 BMP_n_in  in  NUM_BMP  raw asynchronous bump switches, 0 = pressed.
REQ-009 buzz_en  in  1  buzzer request from command processor.
REQ-010 buzz_mode  in  2  00 off, 01 continuous, 10 repeating beep, 11 one-shot.
REQ-011 line_present  in  1  line status for LED display.
REQ-012 led_sel  in  2  LED source select.
REQ-013 BMP_n  out  1  AND of debounced bumps, 0 = any pressed.
REQ-014 bmp_vec  out  NUM_BMP  debounced bump states, 1 = pressed.
REQ-015 bmp_evt  out  1  one-clock pulse when BMP_n falls.
REQ-016 buzz, buzz_n  out  1 each  differential piezo drive.
REQ-017 LED  out  8  registered debug LEDs.

Function
REQ-018 Each bump input SHALL pass a two-flop synchronizer (flops reset to 1).
REQ-019 Per channel, the debounced state SHALL change only after the synchronized value differs from it for DEB_CYC consecutive clocks; counter clears whenever they agree.
REQ-020 BMP_n SHALL be registered; bmp_evt SHALL assert exactly one clock, coincident with the first cycle BMP_n reads 0.
REQ-021 Buzzer FSM states SHALL be IDLE, ON, OFF; the tone counter increments only in ON and clears in IDLE/OFF.
REQ-022 buzz SHALL equal tone counter MSB in ON and 0 otherwise; buzz_n SHALL always equal ~buzz.
REQ-023 Mode 00: FSM SHALL remain IDLE.
REQ-024 Mode 01: IDLE->ON when buzz_en=1; ON->IDLE the clock after buzz_en=0.
REQ-025 Mode 10: IDLE->ON on buzz_en=1; ON->OFF after BEEP_CYC clocks; OFF->ON after BEEP_CYC clocks; any state->IDLE when buzz_en=0.
REQ-026 Mode 11: IDLE->ON on buzz_en rising edge only; ON->IDLE after BEEP_CYC clocks regardless of buzz_en; a held buzz_en SHALL NOT retrigger.
REQ-027 Any change of buzz_mode SHALL force IDLE, clear the tone and beep counters, and take priority over all other transitions that cycle.
REQ-028 Beep phase counter SHALL be wide enough for BEEP_CYC and reset to 0 on each phase entry.
REQ-029 LED (one-clock latency): led_sel 00 = {8{line_present}}; 01 = bmp_vec zero-extended; 10 = {state[1:0], buzz, BMP_n, 4'b0}; 11 = 8'h00.

Reset
REQ-030 On rst_n low: synchronizers and debounced states = 1 (released), bmp_vec = 0, BMP_n = 1, bmp_evt = 0, FSM = IDLE, counters = 0, buzz = 0, buzz_n = 1, LED = 0.
REQ-031 Reset asserted mid-beep or mid-debounce SHALL abort immediately with no residual pulse after release.

Structure
REQ-032 Shared package SHALL hold the buzz_mode and FSM state enums and FAST_SIM effective-value constants.
REQ-033 Per-channel synchronizer+debouncer SHALL be sub-module bmp_debounce, generated NUM_BMP times.

Verification
REQ-034 FAST_SIM=1, BMP_n_in[0] low for 10 clocks then high -> BMP_n stays 1, bmp_evt never pulses.
REQ-035 FAST_SIM=1, BMP_n_in[1] held low -> BMP_n falls 2+16+1 clocks after input edge (±1), bmp_evt single pulse, bmp_vec = 2'b10.
REQ-036 Mode 01, buzz_en high 2^16 clocks -> buzz toggles every 16384 clocks, buzz_n = ~buzz throughout.
REQ-037 FAST_SIM=1, mode 10, buzz_en held -> ON 64 / OFF 64 repeating; buzz_en drop mid-ON -> IDLE next clock, buzz = 0.
REQ-038 Mode 11, buzz_en held 500 clocks -> exactly one 64-clock ON burst; mode changed to 01 mid-burst -> IDLE, counter cleared.
REQ-039 rst_n pulsed low during ON -> buzz = 0, buzz_n = 1, LED = 0 asynchronously.

Source files
------------

// File: rtl/bump_buzz_ctrl_pkg.sv
// Shared types and constants for the bump-switch debouncer and piezo buzzer controller.
// The FAST_SIM values shorten debounce and beep timing so a bench can reach them quickly.
package bump_buzz_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_CONT    = 2'b01,
        MODE_REPEAT  = 2'b10,
        MODE_ONESHOT = 2'b11
    } buzz_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } buzz_state_e;

    localparam int unsigned FAST_DEB_CYC  = 16;
    localparam int unsigned FAST_BEEP_CYC = 64;

    function automatic int unsigned eff_cyc(input int fast, input int unsigned full,
                                            input int unsigned quick);
        return (fast != 0) ? quick : full;
    endfunction

endpackage

// File: rtl/bump_buzz_ctrl_if.sv
// Signal bundle between the command processor / switches and bump_buzz_ctrl.
interface bump_buzz_ctrl_if #(
    parameter int NUM_BMP = 2
);
    // No valid/ready pairs: buzz_en, buzz_mode, led_sel and line_present are level
    // signals sampled every clock; all outputs are registers or decoded from registers.
    logic [NUM_BMP-1:0] BMP_n_in;
    logic               buzz_en;
    logic [1:0]         buzz_mode;
    logic               line_present;
    logic [1:0]         led_sel;

    logic               BMP_n;
    logic [NUM_BMP-1:0] bmp_vec;
    logic               bmp_evt;
    logic               buzz;
    logic               buzz_n;
    logic [7:0]         LED;
    logic [1:0]         state_dbg;

    modport master (
        output BMP_n_in, buzz_en, buzz_mode, line_present, led_sel,
        input  BMP_n, bmp_vec, bmp_evt, buzz, buzz_n, LED, state_dbg
    );

    modport slave (
        input  BMP_n_in, buzz_en, buzz_mode, line_present, led_sel,
        output BMP_n, bmp_vec, bmp_evt, buzz, buzz_n, LED, state_dbg
    );

endinterface

// File: rtl/bump_buzz_ctrl_bmp_debounce.sv
// One bump channel: two-flop synchronizer followed by a consecutive-sample debouncer.
module bmp_debounce #(
    parameter int unsigned DEB_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic pressed
);
    localparam int unsigned CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

    logic          sync1_n;
    logic          sync2_n;
    logic          stable_n;
    logic [CW-1:0] cnt;

    // The stable state flips on the DEB_CYC-th consecutive disagreeing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_n  <= 1'b1;
            sync2_n  <= 1'b1;
            stable_n <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1_n <= raw_n;
            sync2_n <= sync1_n;
            if (sync2_n != stable_n) begin
                if (cnt == LAST) begin
                    stable_n <= sync2_n;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pressed = ~stable_n;

endmodule

// File: rtl/bump_buzz_ctrl.sv
// Bump-switch conditioning plus a three-state piezo buzzer sequencer and debug LED mux.
module bump_buzz_ctrl
    import bump_buzz_ctrl_pkg::*;
#(
    parameter int          NUM_BMP  = 2,
    parameter int unsigned DEB_CYC  = 50000,
    parameter int unsigned BEEP_CYC = 12500000,
    parameter int          TONE_W   = 15,
    parameter int          FAST_SIM = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    bump_buzz_ctrl_if.slave   bus
);
    localparam int unsigned DEB_EFF  = eff_cyc(FAST_SIM, DEB_CYC, FAST_DEB_CYC);
    localparam int unsigned BEEP_EFF = eff_cyc(FAST_SIM, BEEP_CYC, FAST_BEEP_CYC);
    localparam int unsigned BW       = $clog2(BEEP_EFF + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_EFF - 1);

    logic [NUM_BMP-1:0] pressed;
    logic               bmp_n_q;
    logic               bmp_n_d;
    logic               bmp_evt_q;

    for (genvar g = 0; g < NUM_BMP; g++) begin : g_bmp
        bmp_debounce #(.DEB_CYC(DEB_EFF)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_n   (bus.BMP_n_in[g]),
            .pressed (pressed[g])
        );
    end

    assign bmp_n_d = ~|pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmp_n_q   <= 1'b1;
            bmp_evt_q <= 1'b0;
        end else begin
            bmp_n_q   <= bmp_n_d;
            bmp_evt_q <= bmp_n_q & ~bmp_n_d;
        end
    end

    buzz_state_e       state_q, state_d;
    buzz_mode_e        mode;
    logic [1:0]        mode_q;
    logic              en_q;
    logic              mode_chg;
    logic              beep_done;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic [BW-1:0]     beep_q, beep_d;
    logic              buzz;
    logic [7:0]        led_q;

    assign mode      = buzz_mode_e'(bus.buzz_mode);
    assign mode_chg  = (bus.buzz_mode != mode_q);
    assign beep_done = (beep_q == BEEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tone_q  <= '0;
            beep_q  <= '0;
            mode_q  <= 2'b00;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            beep_q  <= beep_d;
            mode_q  <= bus.buzz_mode;
            en_q    <= bus.buzz_en;
        end
    end

    // A mode change overrides every other transition and wipes both counters.
    always_comb begin
        state_d = state_q;
        if (mode_chg) begin
            state_d = ST_IDLE;
        end else begin
            case (mode)
                MODE_OFF: state_d = ST_IDLE;
                MODE_CONT: begin
                    case (state_q)
                        ST_IDLE: if (bus.buzz_en) state_d = ST_ON;
                        ST_ON:   if (!bus.buzz_en) state_d = ST_IDLE;
                        default: state_d = ST_IDLE;
                    endcase
                end
                MODE_REPEAT: begin
                    if (!bus.buzz_en) begin
                        state_d = ST_IDLE;
                    end else begin
                        case (state_q)
                            ST_IDLE: state_d = ST_ON;
                            ST_ON:   if (beep_done) state_d = ST_OFF;
                            ST_OFF:  if (beep_done) state_d = ST_ON;
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
                MODE_ONESHOT: begin
                    case (state_q)
                        ST_IDLE: if (bus.buzz_en && !en_q) state_d = ST_ON;
                        ST_ON:   if (beep_done) state_d = ST_IDLE;
                        default: state_d = ST_IDLE;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end

        beep_d = '0;
        if (!mode_chg && (state_d == state_q) && (state_q != ST_IDLE)) begin
            beep_d = beep_q + 1'b1;
        end

        tone_d = '0;
        if (!mode_chg && (state_d == ST_ON) && (state_q == ST_ON)) begin
            tone_d = tone_q + 1'b1;
        end
    end

    assign buzz = (state_q == ST_ON) & tone_q[TONE_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= 8'h00;
        end else begin
            case (bus.led_sel)
                2'b00:   led_q <= {8{bus.line_present}};
                2'b01:   led_q <= 8'(pressed);
                2'b10:   led_q <= {state_q, buzz, bmp_n_q, 4'b0000};
                default: led_q <= 8'h00;
            endcase
        end
    end

    assign bus.BMP_n     = bmp_n_q;
    assign bus.bmp_vec   = pressed;
    assign bus.bmp_evt   = bmp_evt_q;
    assign bus.buzz      = buzz;
    assign bus.buzz_n    = ~buzz;
    assign bus.LED       = led_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bump_buzz_ctrl.sv
// Directed bench for bump_buzz_ctrl with FAST_SIM timing (debounce 16, beep 64).
module tb_bump_buzz_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ON   = 2'b01;
    localparam logic [1:0] S_OFF  = 2'b10;

    bump_buzz_ctrl_if #(.NUM_BMP(2)) bus ();

    bump_buzz_ctrl #(
        .NUM_BMP  (2),
        .DEB_CYC  (50000),
        .BEEP_CYC (12500000),
        .TONE_W   (15),
        .FAST_SIM (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n            = 1'b0;
        bus.BMP_n_in     = 2'b11;
        bus.buzz_en      = 1'b0;
        bus.buzz_mode    = 2'b00;
        bus.line_present = 1'b0;
        bus.led_sel      = 2'b00;
        tick(3);
        checks++; if (bus.BMP_n !== 1'b1) begin errors++; $display("FAIL reset_BMP_n got %b exp 1", bus.BMP_n); end
        checks++; if (bus.bmp_vec !== 2'b00) begin errors++; $display("FAIL reset_bmp_vec got %b exp 00", bus.bmp_vec); end
        checks++; if (bus.bmp_evt !== 1'b0) begin errors++; $display("FAIL reset_bmp_evt got %b exp 0", bus.bmp_evt); end
        checks++; if (bus.buzz !== 1'b0 || bus.buzz_n !== 1'b1) begin errors++; $display("FAIL reset_buzz got %b/%b exp 0/1", bus.buzz, bus.buzz_n); end
        checks++; if (bus.LED !== 8'h00) begin errors++; $display("FAIL reset_LED got %h exp 00", bus.LED); end
        checks++; if (bus.state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %b exp 00", bus.state_dbg); end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_glitch;
        int bad;
        bad = 0;
        bus.BMP_n_in[0] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 10) bus.BMP_n_in[0] = 1'b1;
            if (bus.BMP_n !== 1'b1 || bus.bmp_evt !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch_reject bad_cycles %0d exp 0", bad); end
        checks++; if (bus.bmp_vec !== 2'b00) begin errors++; $display("FAIL glitch_vec got %b exp 00", bus.bmp_vec); end
    endtask

    task automatic test_press;
        int fall_at;
        int evt_n;
        int evt_at;
        fall_at = 0;
        evt_n   = 0;
        evt_at  = 0;
        bus.BMP_n_in[1] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.BMP_n === 1'b0 && fall_at == 0) fall_at = i;
            if (bus.bmp_evt === 1'b1) begin evt_n++; evt_at = i; end
        end
        checks++; if (fall_at < 18 || fall_at > 20) begin errors++; $display("FAIL press_latency got %0d exp 19", fall_at); end
        checks++; if (evt_n != 1) begin errors++; $display("FAIL press_evt_count got %0d exp 1", evt_n); end
        checks++; if (evt_at != fall_at) begin errors++; $display("FAIL press_evt_align got %0d exp %0d", evt_at, fall_at); end
        checks++; if (bus.bmp_vec !== 2'b10) begin errors++; $display("FAIL press_vec got %b exp 10", bus.bmp_vec); end
        bus.led_sel = 2'b01;
        @(negedge clk);
        checks++; if (bus.LED !== 8'h02) begin errors++; $display("FAIL led_bmp_vec got %h exp 02", bus.LED); end
        bus.led_sel = 2'b00;
        evt_n = 0;
        bus.BMP_n_in[1] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.bmp_evt === 1'b1) evt_n++;
        end
        checks++; if (evt_n != 0) begin errors++; $display("FAIL release_evt got %0d exp 0", evt_n); end
        checks++; if (bus.BMP_n !== 1'b1 || bus.bmp_vec !== 2'b00) begin errors++; $display("FAIL release_state got %b/%b exp 1/00", bus.BMP_n, bus.bmp_vec); end
    endtask

    task automatic test_led;
        bus.line_present = 1'b1;
        bus.led_sel      = 2'b00;
        @(negedge clk);
        checks++; if (bus.LED !== 8'hFF) begin errors++; $display("FAIL led_line got %h exp ff", bus.LED); end
        bus.led_sel = 2'b11;
        @(negedge clk);
        checks++; if (bus.LED !== 8'h00) begin errors++; $display("FAIL led_zero got %h exp 00", bus.LED); end
        bus.led_sel      = 2'b00;
        bus.line_present = 1'b0;
        @(negedge clk);
        checks++; if (bus.LED !== 8'h00) begin errors++; $display("FAIL led_line_low got %h exp 00", bus.LED); end
    endtask

    task automatic test_repeat;
        int bad;
        logic [1:0] exp_st;
        bad = 0;
        bus.buzz_mode = 2'b10;
        bus.buzz_en   = 1'b0;
        tick(2);
        checks++; if (bus.state_dbg !== S_IDLE) begin errors++; $display("FAIL repeat_idle got %b exp 00", bus.state_dbg); end
        bus.buzz_en = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            exp_st = (((k - 1) / 64) % 2 == 0) ? S_ON : S_OFF;
            if (bus.state_dbg !== exp_st || bus.buzz !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL repeat_cadence bad_cycles %0d exp 0", bad); end
        bus.buzz_en = 1'b0;
        @(negedge clk);
        checks++; if (bus.state_dbg !== S_IDLE) begin errors++; $display("FAIL repeat_drop got %b exp 00", bus.state_dbg); end
        checks++; if (bus.buzz !== 1'b0 || bus.buzz_n !== 1'b1) begin errors++; $display("FAIL repeat_drop_buzz got %b/%b exp 0/1", bus.buzz, bus.buzz_n); end
    endtask

    task automatic test_oneshot;
        int on_n;
        int bursts;
        int bad;
        logic prev_on;
        on_n    = 0;
        bursts  = 0;
        bad     = 0;
        prev_on = 1'b0;
        bus.buzz_mode = 2'b11;
        tick(2);
        bus.buzz_en = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            if (bus.state_dbg === S_ON) begin
                on_n++;
                if (!prev_on) bursts++;
            end
            prev_on = (bus.state_dbg === S_ON);
        end
        checks++; if (on_n != 64) begin errors++; $display("FAIL oneshot_len got %0d exp 64", on_n); end
        checks++; if (bursts != 1) begin errors++; $display("FAIL oneshot_bursts got %0d exp 1", bursts); end
        bus.buzz_en = 1'b0;
        tick(2);
        bus.buzz_en = 1'b1;
        tick(10);
        checks++; if (bus.state_dbg !== S_ON) begin errors++; $display("FAIL oneshot_retrig got %b exp 01", bus.state_dbg); end
        bus.buzz_mode = 2'b01;
        @(negedge clk);
        checks++; if (bus.state_dbg !== S_IDLE || bus.buzz !== 1'b0) begin errors++; $display("FAIL mode_chg_abort got %b/%b exp 00/0", bus.state_dbg, bus.buzz); end
        @(negedge clk);
        checks++; if (bus.state_dbg !== S_ON) begin errors++; $display("FAIL mode_chg_cont got %b exp 01", bus.state_dbg); end
        bus.buzz_mode = 2'b11;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.state_dbg !== S_IDLE) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL oneshot_held_en bad_cycles %0d exp 0", bad); end
        bus.buzz_en = 1'b0;
        tick(2);
    endtask

    task automatic test_continuous;
        int   bad;
        int   bad_n;
        int   toggles;
        logic prev_b;
        logic exp_b;
        bad     = 0;
        bad_n   = 0;
        toggles = 0;
        prev_b  = 1'b0;
        bus.buzz_mode = 2'b01;
        bus.buzz_en   = 1'b0;
        tick(2);
        bus.buzz_en = 1'b1;
        for (int i = 1; i <= 65536; i++) begin
            @(negedge clk);
            exp_b = (((i - 1) % 32768) >= 16384);
            if (bus.state_dbg !== S_ON || bus.buzz !== exp_b) bad++;
            if (bus.buzz_n !== ~bus.buzz) bad_n++;
            if (bus.buzz !== prev_b) toggles++;
            prev_b = bus.buzz;
            if (i == 65535) bus.led_sel = 2'b10;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL cont_tone bad_cycles %0d exp 0", bad); end
        checks++; if (bad_n != 0) begin errors++; $display("FAIL cont_buzz_n bad_cycles %0d exp 0", bad_n); end
        checks++; if (toggles != 3) begin errors++; $display("FAIL cont_toggles got %0d exp 3", toggles); end
        checks++; if (bus.LED !== 8'h70) begin errors++; $display("FAIL led_debug got %h exp 70", bus.LED); end
    endtask

    task automatic test_reset_mid;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.buzz !== 1'b0 || bus.buzz_n !== 1'b1) begin errors++; $display("FAIL async_rst_buzz got %b/%b exp 0/1", bus.buzz, bus.buzz_n); end
        checks++; if (bus.LED !== 8'h00) begin errors++; $display("FAIL async_rst_LED got %h exp 00", bus.LED); end
        checks++; if (bus.state_dbg !== S_IDLE) begin errors++; $display("FAIL async_rst_state got %b exp 00", bus.state_dbg); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.state_dbg !== S_IDLE || bus.buzz !== 1'b0) begin errors++; $display("FAIL post_rst_quiet got %b/%b exp 00/0", bus.state_dbg, bus.buzz); end
        checks++; if (bus.LED !== 8'h10) begin errors++; $display("FAIL post_rst_LED got %h exp 10", bus.LED); end
        @(negedge clk);
        checks++; if (bus.state_dbg !== S_ON) begin errors++; $display("FAIL post_rst_on got %b exp 01", bus.state_dbg); end
        bus.buzz_en = 1'b0;
        @(negedge clk);
        checks++; if (bus.state_dbg !== S_IDLE || bus.buzz !== 1'b0) begin errors++; $display("FAIL cont_drop got %b/%b exp 00/0", bus.state_dbg, bus.buzz); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_glitch();
        test_press();
        test_led();
        test_repeat();
        test_oneshot();
        test_continuous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
